// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared opcodes, FSM state encodings and multiply iteration count
//             for the alu_ctrl accumulator controller and its alu datapath.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

   // Command opcodes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_LOAD = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;

   // ALU function selects
   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;
   localparam logic [1:0] SEL_OR  = 2'b11;

   // Controller FSM states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   // Shift-add multiply: one iteration per multiplier bit
   localparam int MUL_ITER = 4;

   // Opcodes 000..011 map directly onto the ALU select lines
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : 4-bit combinational ALU (ADD / SUB / AND / OR) with carry-out
//             and zero flag.
//  Ports    : i_a, i_b   operands
//             i_sel      00 ADD, 01 SUB, 10 AND, 11 OR
//             o_result   4-bit result
//             o_carry    carry-out (SUB: 1 = no borrow; AND/OR: 0)
//             o_zero     o_result == 0
//  Revision : 1.0  initial release
// ============================================================================
module alu
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic [1:0] i_sel,
   output logic [3:0] o_result,
   output logic       o_carry,
   output logic       o_zero
);

   logic [3:0] w_neg_b;
   logic [4:0] w_sum;
   logic [4:0] w_diff;

   // Two's complement negate kept at 4 bits: b=0 gives 0, so SUB 0 has carry 0
   assign w_neg_b = (~i_b) + 4'd1;
   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff  = {1'b0, i_a} + {1'b0, w_neg_b};

   always_comb begin
      o_result = 4'h0;
      o_carry  = 1'b0;
      case (i_sel)
         SEL_ADD: {o_carry, o_result} = w_sum;
         SEL_SUB: {o_carry, o_result} = w_diff;
         SEL_AND: o_result = i_a & i_b;
         default: o_result = i_a | i_b;
      endcase
   end

   assign o_zero = (o_result == 4'h0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl
//  Purpose  : Command-driven 4-bit accumulator controller in front of a shared
//             alu. One command in flight; ALU ops take one execute cycle, MUL
//             takes four shift-add iterations through the same alu.
//  Ports    : clk, rst                     clock, async active-high reset
//             i_cmd_valid / o_cmd_ready    command handshake
//             i_cmd_op, i_cmd_operand      opcode and operand B
//             o_rsp_valid / i_rsp_ready    response handshake
//             o_rsp_result/carry/zero/err  response payload (held outside RESP)
//             o_acc                        current accumulator
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl
   import alu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [2:0] i_cmd_op,
   input  logic [3:0] i_cmd_operand,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [3:0] o_rsp_result,
   output logic       o_rsp_carry,
   output logic       o_rsp_zero,
   output logic       o_rsp_err,
   output logic [3:0] o_acc
);

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [2:0] r_op;
   logic [3:0] r_operand;
   logic [3:0] r_acc;
   logic [3:0] r_hi;
   logic [3:0] r_lo;
   logic [1:0] r_cnt;
   logic [3:0] r_rsp_result;
   logic       r_rsp_carry;
   logic       r_rsp_zero;
   logic       r_rsp_err;

   logic       w_cmd_fire;
   logic       w_rsp_fire;
   logic       w_mul_last;
   logic [3:0] w_alu_a;
   logic [3:0] w_alu_b;
   logic [1:0] w_alu_sel;
   logic [3:0] w_alu_result;
   logic       w_alu_carry;
   logic       w_alu_zero;
   logic [3:0] w_ex_result;
   logic       w_ex_carry;
   logic       w_ex_zero;
   logic       w_ex_err;
   logic       w_mul_c;
   logic [3:0] w_mul_sum;
   logic [3:0] w_mul_hi_n;
   logic [3:0] w_mul_lo_n;

   assign w_cmd_fire = i_cmd_valid & o_cmd_ready;
   assign w_rsp_fire = o_rsp_valid & i_rsp_ready;
   assign w_mul_last = (r_cnt == 2'(MUL_ITER - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_cmd_fire) w_next_state = (i_cmd_op == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC: w_next_state = S_RESP;
         S_MUL:  if (w_mul_last) w_next_state = S_RESP;
         default: if (w_rsp_fire) w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // cmd_ready is gated by rst so nothing looks acceptable while reset is held
   always_comb begin
      o_cmd_ready = (r_state == S_IDLE) & ~rst;
      o_rsp_valid = (r_state == S_RESP);
   end

   // ---------------- shared alu ----------------
   // MUL accumulates the multiplicand (acc) into hi; EXEC works on acc/operand
   assign w_alu_a   = (r_state == S_MUL) ? r_hi  : r_acc;
   assign w_alu_b   = (r_state == S_MUL) ? r_acc : r_operand;
   assign w_alu_sel = (r_state == S_MUL) ? SEL_ADD : r_op[1:0];

   alu u_alu (
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_sel    (w_alu_sel),
      .o_result (w_alu_result),
      .o_carry  (w_alu_carry),
      .o_zero   (w_alu_zero)
   );

   // ---------------- single-cycle op results ----------------
   always_comb begin
      w_ex_result = r_acc;
      w_ex_carry  = 1'b0;
      w_ex_zero   = (r_acc == 4'h0);
      w_ex_err    = 1'b0;
      if (is_alu_op(r_op)) begin
         w_ex_result = w_alu_result;
         w_ex_carry  = w_alu_carry;
         w_ex_zero   = w_alu_zero;
      end else if (r_op == OP_LOAD) begin
         w_ex_result = r_operand;
         w_ex_zero   = (r_operand == 4'h0);
      end else if (r_op == OP_CLR) begin
         w_ex_result = 4'h0;
         w_ex_zero   = 1'b1;
      end else begin
         // reserved opcode: accumulator passes through untouched
         w_ex_err    = 1'b1;
      end
   end

   // ---------------- shift-add iteration ----------------
   // {c,hi,lo} after optional add, shifted right by one
   assign w_mul_c    = r_lo[0] & w_alu_carry;
   assign w_mul_sum  = r_lo[0] ? w_alu_result : r_hi;
   assign w_mul_hi_n = {w_mul_c, w_mul_sum[3:1]};
   assign w_mul_lo_n = {w_mul_sum[0], r_lo[3:1]};

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= 3'b000;
         r_operand    <= 4'h0;
         r_acc        <= 4'h0;
         r_hi         <= 4'h0;
         r_lo         <= 4'h0;
         r_cnt        <= 2'd0;
         r_rsp_result <= 4'h0;
         r_rsp_carry  <= 1'b0;
         r_rsp_zero   <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_op      <= i_cmd_op;
                  r_operand <= i_cmd_operand;
                  r_hi      <= 4'h0;
                  r_lo      <= i_cmd_operand;
                  r_cnt     <= 2'd0;
               end
            end
            S_EXEC: begin
               r_acc        <= w_ex_result;
               r_rsp_result <= w_ex_result;
               r_rsp_carry  <= w_ex_carry;
               r_rsp_zero   <= w_ex_zero;
               r_rsp_err    <= w_ex_err;
            end
            S_MUL: begin
               r_hi  <= w_mul_hi_n;
               r_lo  <= w_mul_lo_n;
               r_cnt <= r_cnt + 2'd1;
               if (w_mul_last) begin
                  // product overflow is anything left in the high nibble
                  r_acc        <= w_mul_lo_n;
                  r_rsp_result <= w_mul_lo_n;
                  r_rsp_carry  <= |w_mul_hi_n;
                  r_rsp_zero   <= (w_mul_lo_n == 4'h0);
                  r_rsp_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_rsp_result = r_rsp_result;
   assign o_rsp_carry  = r_rsp_carry;
   assign o_rsp_zero   = r_rsp_zero;
   assign o_rsp_err    = r_rsp_err;
   assign o_acc        = r_acc;

endmodule : alu_ctrl
`default_nettype wire
